// File: rtl/led_phase_scheduler.sv
// IR/RED LED phase scheduler: time-multiplexes one ADC/DAC/PGA front-end between
// two LED channels and publishes per-channel averaged ADC values.
module led_phase_scheduler #(
  parameter int unsigned SETTLE_CYC = 5,
  parameter int unsigned LOG2_AVG   = 2,
  parameter int unsigned DARK_CYC   = 10
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       Enable,
  input  logic [7:0] ADC,
  input  logic [6:0] IR_DC_Comp_Set,
  input  logic [3:0] IR_Gain_Set,
  input  logic [6:0] RED_DC_Comp_Set,
  input  logic [3:0] RED_Gain_Set,
  output logic       LED_IR,
  output logic       LED_RED,
  output logic [6:0] DC_Comp,
  output logic [3:0] PGA_Gain,
  output logic [7:0] IR_ADC_Value,
  output logic [7:0] RED_ADC_Value,
  output logic       IR_Valid,
  output logic       RED_Valid,
  output logic       Frame_Done,
  output logic       Busy
);

  localparam int unsigned AW          = 8 + LOG2_AVG;
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0]  SAMPLE_LAST = 8'((1 << LOG2_AVG) - 1);
  localparam logic [7:0]  DARK_LAST   = 8'(DARK_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, IR_SETTLE, IR_SAMPLE, DARK1, RED_SETTLE, RED_SAMPLE, DARK2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [AW-1:0]   acc_q, acc_d, sum;
  logic [6:0]      ir_dc_q, ir_dc_d, red_dc_q, red_dc_d;
  logic [3:0]      ir_gain_q, ir_gain_d, red_gain_q, red_gain_d;
  logic [7:0]      ir_val_q, ir_val_d, red_val_q, red_val_d;
  logic            ir_vld_d, red_vld_d, done_d, start;
  logic            led_ir_q, led_ir_d, led_red_q, led_red_d, busy_q, busy_d;
  logic            ir_vld_q, red_vld_q, done_q;
  logic [6:0]      dc_q, dc_d;
  logic [3:0]      gain_q, gain_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 8'd1;
    acc_d      = acc_q;
    ir_dc_d    = ir_dc_q;
    ir_gain_d  = ir_gain_q;
    red_dc_d   = red_dc_q;
    red_gain_d = red_gain_q;
    ir_val_d   = ir_val_q;
    red_val_d  = red_val_q;
    ir_vld_d   = 1'b0;
    red_vld_d  = 1'b0;
    done_d     = 1'b0;
    start      = 1'b0;
    sum        = acc_q + AW'(ADC);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        start = Enable;
      end
      IR_SETTLE, RED_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = (state_q == IR_SETTLE) ? IR_SAMPLE : RED_SAMPLE;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      IR_SAMPLE, RED_SAMPLE: begin
        acc_d = sum;
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d = '0;
          if (state_q == IR_SAMPLE) begin
            state_d  = DARK1;
            ir_val_d = 8'(sum >> LOG2_AVG);
            ir_vld_d = 1'b1;
          end else begin
            state_d   = DARK2;
            red_val_d = 8'(sum >> LOG2_AVG);
            red_vld_d = 1'b1;
          end
        end
      end
      DARK1: begin
        if (cnt_q == DARK_LAST) begin
          state_d = RED_SETTLE;
          cnt_d   = '0;
        end
      end
      DARK2: begin
        if (cnt_q == DARK_LAST) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
          start   = Enable;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A frame start (from IDLE or straight out of DARK2) snapshots the settings.
    if (start) begin
      state_d    = IR_SETTLE;
      cnt_d      = '0;
      ir_dc_d    = IR_DC_Comp_Set;
      ir_gain_d  = IR_Gain_Set;
      red_dc_d   = RED_DC_Comp_Set;
      red_gain_d = RED_Gain_Set;
    end

    led_ir_d  = (state_d == IR_SETTLE) || (state_d == IR_SAMPLE);
    led_red_d = (state_d == RED_SETTLE) || (state_d == RED_SAMPLE);
    busy_d    = (state_d != IDLE);
    case (state_d)
      IR_SETTLE, IR_SAMPLE, DARK1: begin
        dc_d   = ir_dc_d;
        gain_d = ir_gain_d;
      end
      RED_SETTLE, RED_SAMPLE, DARK2: begin
        dc_d   = red_dc_d;
        gain_d = red_gain_d;
      end
      default: begin
        dc_d   = '0;
        gain_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      ir_dc_q    <= '0;
      ir_gain_q  <= '0;
      red_dc_q   <= '0;
      red_gain_q <= '0;
      ir_val_q   <= '0;
      red_val_q  <= '0;
      ir_vld_q   <= 1'b0;
      red_vld_q  <= 1'b0;
      done_q     <= 1'b0;
      led_ir_q   <= 1'b0;
      led_red_q  <= 1'b0;
      busy_q     <= 1'b0;
      dc_q       <= '0;
      gain_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ir_dc_q    <= ir_dc_d;
      ir_gain_q  <= ir_gain_d;
      red_dc_q   <= red_dc_d;
      red_gain_q <= red_gain_d;
      ir_val_q   <= ir_val_d;
      red_val_q  <= red_val_d;
      ir_vld_q   <= ir_vld_d;
      red_vld_q  <= red_vld_d;
      done_q     <= done_d;
      led_ir_q   <= led_ir_d;
      led_red_q  <= led_red_d;
      busy_q     <= busy_d;
      dc_q       <= dc_d;
      gain_q     <= gain_d;
    end
  end

  assign LED_IR        = led_ir_q;
  assign LED_RED       = led_red_q;
  assign DC_Comp       = dc_q;
  assign PGA_Gain      = gain_q;
  assign IR_ADC_Value  = ir_val_q;
  assign RED_ADC_Value = red_val_q;
  assign IR_Valid      = ir_vld_q;
  assign RED_Valid     = red_vld_q;
  assign Frame_Done    = done_q;
  assign Busy          = busy_q;

endmodule

// File: tb/tb_led_phase_scheduler.sv
// Scoreboard bench for led_phase_scheduler: expected averages and strobe cycles are
// queued when a frame is launched and compared when the DUT strobes.
module tb_led_phase_scheduler;

  localparam int unsigned S  = 5;
  localparam int unsigned L  = 2;
  localparam int unsigned A  = 4;
  localparam int unsigned D  = 10;
  localparam int unsigned FL = 2 * (S + A + D);

  logic       CLK = 1'b0;
  logic       rst_n, Enable;
  logic [7:0] ADC;
  logic [6:0] IR_DC_Comp_Set, RED_DC_Comp_Set;
  logic [3:0] IR_Gain_Set, RED_Gain_Set;
  logic       LED_IR, LED_RED, IR_Valid, RED_Valid, Frame_Done, Busy;
  logic [6:0] DC_Comp;
  logic [3:0] PGA_Gain;
  logic [7:0] IR_ADC_Value, RED_ADC_Value;

  always #5 CLK = ~CLK;

  led_phase_scheduler #(
    .SETTLE_CYC(S),
    .LOG2_AVG  (L),
    .DARK_CYC  (D)
  ) dut (
    .CLK            (CLK),
    .rst_n          (rst_n),
    .Enable         (Enable),
    .ADC            (ADC),
    .IR_DC_Comp_Set (IR_DC_Comp_Set),
    .IR_Gain_Set    (IR_Gain_Set),
    .RED_DC_Comp_Set(RED_DC_Comp_Set),
    .RED_Gain_Set   (RED_Gain_Set),
    .LED_IR         (LED_IR),
    .LED_RED        (LED_RED),
    .DC_Comp        (DC_Comp),
    .PGA_Gain       (PGA_Gain),
    .IR_ADC_Value   (IR_ADC_Value),
    .RED_ADC_Value  (RED_ADC_Value),
    .IR_Valid       (IR_Valid),
    .RED_Valid      (RED_Valid),
    .Frame_Done     (Frame_Done),
    .Busy           (Busy)
  );

  typedef struct {
    logic [7:0]  val;
    int unsigned at;
  } exp_t;

  exp_t        ir_q[$], red_q[$], mon_e;
  int unsigned done_q[$];
  int unsigned cyc = 0;
  int unsigned total = 0, bad = 0;
  int unsigned ir_k = 0, red_k = 0;
  logic        mon_en = 1'b0;
  logic [7:0]  ir_samp[4], red_samp[4];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] avg4(input logic [7:0] a0, a1, a2, a3);
    int unsigned s;
    s = a0 + a1 + a2 + a3;
    return 8'(s >> L);
  endfunction

  // Monitor pops the scoreboard on strobes; the ADC source feeds per-LED sample sequences.
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("led_excl", LED_IR & LED_RED, 0);
      if (IR_Valid) begin
        if (ir_q.size() == 0) chk("ir_extra", IR_Valid, 0);
        else begin
          mon_e = ir_q.pop_front();
          chk("ir_val", IR_ADC_Value, mon_e.val);
          chk("ir_at", cyc, mon_e.at);
        end
      end
      if (RED_Valid) begin
        if (red_q.size() == 0) chk("red_extra", RED_Valid, 0);
        else begin
          mon_e = red_q.pop_front();
          chk("red_val", RED_ADC_Value, mon_e.val);
          chk("red_at", cyc, mon_e.at);
        end
      end
      if (Frame_Done) begin
        if (done_q.size() == 0) chk("done_extra", Frame_Done, 0);
        else chk("done_at", cyc, done_q.pop_front());
      end
    end
    if (LED_IR === 1'b1) begin
      ADC = (ir_k < S) ? 8'd222 : ir_samp[(ir_k - S) % A];
      ir_k++;
    end else begin
      ir_k = 0;
    end
    if (LED_RED === 1'b1) begin
      ADC = (red_k < S) ? 8'd222 : red_samp[(red_k - S) % A];
      red_k++;
    end else begin
      red_k = 0;
    end
    if (LED_IR !== 1'b1 && LED_RED !== 1'b1) ADC = 8'd7;
  end

  task automatic wait_until(input int unsigned t);
    while (cyc < t) @(negedge CLK);
  endtask

  task automatic run_start(input int unsigned n, output int unsigned nn);
    logic [7:0] ei, er;
    ei = avg4(ir_samp[0], ir_samp[1], ir_samp[2], ir_samp[3]);
    er = avg4(red_samp[0], red_samp[1], red_samp[2], red_samp[3]);
    Enable = 1'b1;
    nn = cyc + 1;
    for (int unsigned k = 0; k < n; k++) begin
      ir_q.push_back('{val: ei, at: nn + FL * k + S + A});
      red_q.push_back('{val: er, at: nn + FL * k + 2 * S + 2 * A + D});
      done_q.push_back(nn + FL * (k + 1));
    end
  endtask

  task automatic chk_quiet(input string tag, input logic [7:0] ev_ir, input logic [7:0] ev_red);
    chk({tag, "_ctl"}, {LED_IR, LED_RED, DC_Comp, PGA_Gain, IR_Valid, RED_Valid, Frame_Done, Busy}, 0);
    chk({tag, "_vals"}, {IR_ADC_Value, RED_ADC_Value}, {ev_ir, ev_red});
  endtask

  task automatic set_samples(input logic [7:0] i0, i1, i2, i3, r0, r1, r2, r3);
    ir_samp[0] = i0; ir_samp[1] = i1; ir_samp[2] = i2; ir_samp[3] = i3;
    red_samp[0] = r0; red_samp[1] = r1; red_samp[2] = r2; red_samp[3] = r3;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int unsigned nn;
    rst_n           = 1'b0;
    Enable          = 1'b0;
    IR_DC_Comp_Set  = 7'h12;
    IR_Gain_Set     = 4'd3;
    RED_DC_Comp_Set = 7'h45;
    RED_Gain_Set    = 4'd9;
    set_samples(100, 100, 100, 100, 50, 50, 50, 50);
    @(negedge CLK);
    wait_until(2);
    chk_quiet("reset", 8'd0, 8'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk_quiet("idle", 8'd0, 8'd0);
    end

    // Defaults, settings muxing and shadowing of a mid-frame change.
    run_start(1, nn);
    wait_until(nn);
    Enable = 1'b0;
    wait_until(nn + 1);
    chk("ir_settle_set", {DC_Comp, PGA_Gain, LED_IR, LED_RED, Busy}, {7'h12, 4'd3, 3'b101});
    wait_until(nn + S + A + 1);
    chk("dark1_set", {DC_Comp, PGA_Gain, LED_IR, LED_RED, Busy}, {7'h12, 4'd3, 3'b001});
    wait_until(nn + S + A + D + 1);
    chk("red_settle_set", {DC_Comp, PGA_Gain, LED_IR, LED_RED, Busy}, {7'h45, 4'd9, 3'b011});
    IR_Gain_Set = 4'd7;
    wait_until(nn + S + A + D + 2);
    chk("red_settle_shadow", PGA_Gain, 4'd9);
    wait_until(nn + FL - 1);
    chk("dark2_set", {DC_Comp, PGA_Gain, LED_IR, LED_RED, Busy}, {7'h45, 4'd9, 3'b001});
    wait_until(nn + FL);
    chk("frame_end_idle", {Frame_Done, Busy, LED_IR}, 3'b100);
    wait_until(nn + FL + 1);
    chk_quiet("after_f1", 8'd100, 8'd50);

    // Floor averaging on IR, full-scale on RED, new IR gain from this frame.
    set_samples(10, 20, 30, 41, 255, 255, 255, 255);
    run_start(1, nn);
    wait_until(nn);
    Enable = 1'b0;
    wait_until(nn + 1);
    chk("new_gain", {DC_Comp, PGA_Gain}, {7'h12, 4'd7});
    wait_until(nn + FL + 1);
    chk_quiet("after_f2", 8'd25, 8'd255);

    // Five back-to-back frames.
    set_samples(1, 2, 3, 4, 0, 0, 0, 3);
    run_start(5, nn);
    for (int unsigned k = 1; k < 5; k++) begin
      wait_until(nn + FL * k);
      chk("cont_boundary", {Frame_Done, LED_IR, Busy}, 3'b111);
    end
    Enable = 1'b0;
    wait_until(nn + FL * 5 + 1);
    chk_quiet("after_cont", 8'd2, 8'd0);

    // Reset after two IR samples; the partial sum must not leak into the next frame.
    set_samples(200, 200, 200, 200, 200, 200, 200, 200);
    run_start(1, nn);
    wait_until(nn);
    Enable = 1'b0;
    wait_until(nn + S + 2);
    rst_n = 1'b0;
    wait_until(nn + S + 3);
    ir_q.delete();
    red_q.delete();
    done_q.delete();
    chk_quiet("mid_reset", 8'd0, 8'd0);
    rst_n = 1'b1;
    wait_until(nn + S + 5);
    chk_quiet("post_reset", 8'd0, 8'd0);
    set_samples(8, 8, 8, 8, 9, 9, 9, 10);
    run_start(1, nn);
    wait_until(nn);
    Enable = 1'b0;
    wait_until(nn + FL + 3);
    chk_quiet("after_recover", 8'd8, 8'd9);

    chk("sb_ir_left", ir_q.size(), 0);
    chk("sb_red_left", red_q.size(), 0);
    chk("sb_done_left", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
